fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-stage program counter and F/D pipeline register for the five-stage MIPS pipeline. Holds the architectural fetch PC, drives the instruction-memory address, and each cycle selects the next PC from four sources: sequential PC+4, branch target, jump target `npc_j` (`{PC4_D[31:28],IR[25:0],2'b00}`), or jump-register value. It captures the fetched word into the D-stage register (`IR_D`, `PC_D`, `PC4_D`), which feeds decode and the jump/branch target calculators. Supports stall from the hazard unit and a redirect bubble when delay slots are compiled out.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch PC after reset
- `NOP_WORD`, 32'h0000_0000, instruction word inserted as a bubble
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  hold PC and F/D register (from hazard unit)
- `npc_sel`  in  2  next-PC source: 00 PC+4, 01 branch, 10 jump (j/jal), 11 jump-register
- `npc_b`  in  32  branch target from D stage
- `npc_j`  in  32  jump target from D stage
- `npc_jr`  in  32  forwarded rs value for jr/jalr
- `pc_F`  out  32  current fetch address to instruction memory
- `instr_F`  in  32  instruction word at `pc_F` (combinational IM read)
- `IR_D`  out  32  D-stage instruction
- `PC_D`  out  32  D-stage PC
- `PC4_D`  out  32  D-stage PC+4
- `valid_D`  out  1  1 = `IR_D` is a real fetched instruction, 0 = bubble
- `fetch_cnt`  out  32  count of real instructions loaded into D

## Operation
- `npc_sel` is asserted by decode for the instruction currently in D; redirect = `npc_sel != 2'b00`.
- Next PC: 00 -> `pc_F+4`; 01 -> `npc_b`; 10 -> `npc_j`; 11 -> `npc_jr`. Bits [1:0] of the selected value are forced to 00 before being loaded into the PC register. Additions wrap modulo 2^32; no overflow detection.
- Normal cycle (`stall`=0): PC <= next PC; F/D <= {`instr_F`, `pc_F`, `pc_F+4`}, `valid_D`<=1, `fetch_cnt`+=1.
- Stall (`stall`=1): PC, `IR_D`, `PC_D`, `PC4_D`, `valid_D`, `fetch_cnt` all hold. Stall overrides redirect; decode keeps presenting the same `npc_sel`, so the redirect is taken on the first unstalled cycle.
- Redirect without delay slot (see Configuration): F/D loads a bubble: `IR_D`=`NOP_WORD`, `PC_D`=`pc_F`, `PC4_D`=`pc_F+4`, `valid_D`=0; `fetch_cnt` unchanged.
- Reset has priority over stall and redirect.

## Timing
- Reset values: `pc_F`=`RESET_PC`, `IR_D`=`NOP_WORD`, `PC_D`=0, `PC4_D`=0, `valid_D`=0, `fetch_cnt`=0.
- First real instruction reaches `IR_D` one edge after reset deasserts.
- `pc_F` changes only on a rising clock edge. Instruction fetch latency is 1 cycle from `pc_F` to `IR_D`.
- Redirect latency: the target appears on `pc_F` one edge after the cycle in which `npc_sel` is sampled with `stall`=0.
- Reset asserted mid-stall or mid-redirect: all state returns to the reset values on that edge. Pending redirect is discarded.
- `fetch_cnt` wraps from 32'hFFFF_FFFF to 0.

## Configuration
- `DELAY_SLOT_EN` defined: MIPS delay-slot semantics. On a redirect, the instruction fetched that cycle (the delay slot) is loaded into F/D normally (`valid_D`=1, counted). No bubble is generated.
- `DELAY_SLOT_EN` undefined: on a redirect, the fetched instruction is squashed and replaced by the bubble described in Operation.

## Test plan
- Reset held 2 cycles then released with `npc_sel`=00: `pc_F` is 3000, 3004, 3008. `IR_D` equals the IM word at 3000 one cycle after release, `valid_D`=1, `fetch_cnt`=1.
- `stall`=1 for 3 cycles at `pc_F`=3008: `pc_F`, `IR_D`, and `fetch_cnt` are unchanged for 3 cycles, then resume at 300C.
- j in D with `npc_j`=0000_3100, `npc_sel`=10, `pc_F`=3010: next `pc_F`=3100. With `DELAY_SLOT_EN`, `IR_D` = word@3010 with `valid_D`=1. Without it, `IR_D`=0, `valid_D`=0, and `PC_D`=3010.
- jr with `npc_jr`=0000_3203 and `stall`=1 for one cycle, then 0: PC holds during the stall, then `pc_F`=3200 (low bits forced to 00).
- Branch redirect with `npc_b`=3040 and `reset` asserted the same cycle: `pc_F`=3000 and all outputs take their reset values.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register and F/D pipeline register for the five-stage MIPS pipeline.
// Optional feature macro: DELAY_SLOT_EN (defined = MIPS delay slot, undefined = squash on redirect).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] npc_b,
    input  logic [31:0] npc_j,
    input  logic [31:0] npc_jr,
    output logic [31:0] pc_F,
    input  logic [31:0] instr_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic        valid_D,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4d_q, pc4d_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] npc_raw;
    logic        redirect;
    logic        squash;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = (npc_sel != 2'b00);

    always_comb begin
        npc_raw = pc_plus4;
        case (npc_sel)
            2'b00:   npc_raw = pc_plus4;
            2'b01:   npc_raw = npc_b;
            2'b10:   npc_raw = npc_j;
            default: npc_raw = npc_jr;
        endcase
    end

`ifdef DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    assign squash = redirect;
`endif

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcd_d   = pcd_q;
        pc4d_d  = pc4d_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            // word alignment is enforced here so a stray jr target cannot misalign fetch
            pc_d   = {npc_raw[31:2], 2'b00};
            pcd_d  = pc_q;
            pc4d_d = pc_plus4;
            if (squash) begin
                ir_d    = NOP_WORD;
                valid_d = 1'b0;
            end else begin
                ir_d    = instr_F;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ir_q    <= NOP_WORD;
            pcd_q   <= 32'd0;
            pc4d_q  <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcd_q   <= pcd_d;
            pc4d_q  <= pc4d_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_F      = pc_q;
    assign IR_D      = ir_q;
    assign PC_D      = pcd_q;
    assign PC4_D     = pc4d_q;
    assign valid_D   = valid_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: reference model feeds a scoreboard queue, plus
// fixed-value checks of the documented scenarios.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic [31:0] npc_b = 32'd0, npc_j = 32'd0, npc_jr = 32'd0;
    logic [31:0] pc_F, instr_F, IR_D, PC_D, PC4_D, fetch_cnt;
    logic        valid_D;

    fetch_pc_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
        .npc_b(npc_b), .npc_j(npc_j), .npc_jr(npc_jr),
        .pc_F(pc_F), .instr_F(instr_F),
        .IR_D(IR_D), .PC_D(PC_D), .PC4_D(PC4_D),
        .valid_D(valid_D), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign instr_F = im(pc_F);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pcd;
        logic [31:0] pc4d;
        logic        v;
        logic [31:0] cnt;
    } st_t;

    st_t m;
    st_t e, g;
    st_t sb[$];
    int  n_chk = 0;
    int  n_pass = 0;

    function automatic st_t snap();
        return {pc_F, IR_D, PC_D, PC4_D, valid_D, fetch_cnt};
    endfunction

    // Drive one cycle of inputs, push the model's post-edge expectation, advance one edge.
    task automatic cyc(input logic r, input logic s, input logic [1:0] sel, input logic [31:0] tgt);
        logic [31:0] nx;
        logic        sq;
        reset   = r;
        stall   = s;
        npc_sel = sel;
        npc_b   = (sel == 2'b01) ? tgt : 32'hDEAD_0010;
        npc_j   = (sel == 2'b10) ? tgt : 32'hBEEF_0020;
        npc_jr  = (sel == 2'b11) ? tgt : 32'hCAFE_0030;
        if (r) begin
            m = {RST_PC, NOP, 32'd0, 32'd0, 1'b0, 32'd0};
        end else if (!s) begin
            case (sel)
                2'b00:   nx = m.pc + 32'd4;
                default: nx = tgt;
            endcase
            nx[1:0] = 2'b00;
`ifdef DELAY_SLOT_EN
            sq = 1'b0;
`else
            sq = (sel != 2'b00);
`endif
            m.pcd  = m.pc;
            m.pc4d = m.pc + 32'd4;
            if (sq) begin
                m.ir = NOP;
                m.v  = 1'b0;
            end else begin
                m.ir  = im(m.pc);
                m.v   = 1'b1;
                m.cnt = m.cnt + 32'd1;
            end
            m.pc = nx;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 2'b00, 32'd0);
            e = sb.pop_front(); g = snap(); n_chk++;
            if (g !== e) $display("FAIL reset_hold got=%h exp=%h", g, e); else n_pass++;
        end
        n_chk++;
        if (pc_F !== 32'h3000 || valid_D !== 1'b0 || fetch_cnt !== 32'd0)
            $display("FAIL reset_vals pc=%h v=%b cnt=%0d exp pc=3000 v=0 cnt=0", pc_F, valid_D, fetch_cnt);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 32'd0);
            e = sb.pop_front(); g = snap(); n_chk++;
            if (g !== e) $display("FAIL reset_release got=%h exp=%h", g, e); else n_pass++;
            if (i == 0) begin
                n_chk++;
                if (pc_F !== 32'h3004 || IR_D !== im(32'h3000) || valid_D !== 1'b1 || fetch_cnt !== 32'd1)
                    $display("FAIL first_fetch pc=%h ir=%h v=%b cnt=%0d exp pc=3004 ir=%h v=1 cnt=1",
                             pc_F, IR_D, valid_D, fetch_cnt, im(32'h3000));
                else n_pass++;
            end
        end
        n_chk++;
        if (pc_F !== 32'h3008) $display("FAIL seq_pc got=%h exp=00003008", pc_F); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 32'd0);
            e = sb.pop_front(); g = snap(); n_chk++;
            if (g !== e) $display("FAIL stall_model got=%h exp=%h", g, e); else n_pass++;
            n_chk++;
            if (pc_F !== 32'h3008 || IR_D !== im(32'h3004) || fetch_cnt !== 32'd2)
                $display("FAIL stall_hold pc=%h ir=%h cnt=%0d exp pc=3008 ir=%h cnt=2",
                         pc_F, IR_D, fetch_cnt, im(32'h3004));
            else n_pass++;
        end
        cyc(1'b0, 1'b0, 2'b00, 32'd0);
        e = sb.pop_front(); g = snap(); n_chk++;
        if (g !== e) $display("FAIL stall_resume got=%h exp=%h", g, e); else n_pass++;
        n_chk++;
        if (pc_F !== 32'h300C || IR_D !== im(32'h3008) || fetch_cnt !== 32'd3)
            $display("FAIL stall_resume_pc pc=%h cnt=%0d exp pc=300c cnt=3", pc_F, fetch_cnt);
        else n_pass++;
    endtask

    task automatic test_jump();
        cyc(1'b0, 1'b0, 2'b00, 32'd0);
        e = sb.pop_front(); g = snap(); n_chk++;
        if (g !== e) $display("FAIL jump_pre got=%h exp=%h", g, e); else n_pass++;
        cyc(1'b0, 1'b0, 2'b10, 32'h0000_3100);
        e = sb.pop_front(); g = snap(); n_chk++;
        if (g !== e) $display("FAIL jump_model got=%h exp=%h", g, e); else n_pass++;
        n_chk++;
`ifdef DELAY_SLOT_EN
        if (pc_F !== 32'h3100 || IR_D !== im(32'h3010) || valid_D !== 1'b1 || fetch_cnt !== 32'd5)
            $display("FAIL jump_dslot pc=%h ir=%h v=%b cnt=%0d exp pc=3100 ir=%h v=1 cnt=5",
                     pc_F, IR_D, valid_D, fetch_cnt, im(32'h3010));
        else n_pass++;
`else
        if (pc_F !== 32'h3100 || IR_D !== 32'd0 || valid_D !== 1'b0 || PC_D !== 32'h3010 || fetch_cnt !== 32'd4)
            $display("FAIL jump_bubble pc=%h ir=%h v=%b pcd=%h cnt=%0d exp pc=3100 ir=0 v=0 pcd=3010 cnt=4",
                     pc_F, IR_D, valid_D, PC_D, fetch_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_jr_stall();
        cyc(1'b0, 1'b1, 2'b11, 32'h0000_3203);
        e = sb.pop_front(); g = snap(); n_chk++;
        if (g !== e) $display("FAIL jr_stall got=%h exp=%h", g, e); else n_pass++;
        n_chk++;
        if (pc_F !== 32'h3100) $display("FAIL jr_hold got=%h exp=00003100", pc_F); else n_pass++;
        cyc(1'b0, 1'b0, 2'b11, 32'h0000_3203);
        e = sb.pop_front(); g = snap(); n_chk++;
        if (g !== e) $display("FAIL jr_take got=%h exp=%h", g, e); else n_pass++;
        n_chk++;
        if (pc_F !== 32'h3200) $display("FAIL jr_align got=%h exp=00003200", pc_F); else n_pass++;
    endtask

    task automatic test_reset_redirect();
        cyc(1'b0, 1'b0, 2'b00, 32'd0);
        e = sb.pop_front(); g = snap(); n_chk++;
        if (g !== e) $display("FAIL rr_pre got=%h exp=%h", g, e); else n_pass++;
        cyc(1'b1, 1'b1, 2'b01, 32'h0000_3040);
        e = sb.pop_front(); g = snap(); n_chk++;
        if (g !== e) $display("FAIL rr_model got=%h exp=%h", g, e); else n_pass++;
        n_chk++;
        if (g !== {RST_PC, NOP, 32'd0, 32'd0, 1'b0, 32'd0})
            $display("FAIL rr_reset got=%h exp=%h", g, {RST_PC, NOP, 32'd0, 32'd0, 1'b0, 32'd0});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] sel;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i % 4);
            cyc(1'b0, 1'b0, sel, 32'h0000_4001 + 32'(i * 32'h104));
            e = sb.pop_front(); g = snap(); n_chk++;
            if (g !== e) $display("FAIL b2b_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end
        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(29) == 0), ($urandom_range(3) == 0),
                2'($urandom_range(3)), $urandom);
            e = sb.pop_front(); g = snap(); n_chk++;
            if (g !== e) $display("FAIL rand_%0d got=%h exp=%h", i, g, e); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_stall();
        test_jump();
        test_jr_stall();
        test_reset_redirect();
        test_back_to_back();
        n_chk++;
        if (sb.size() != 0) $display("FAIL sb_drain left=%0d exp=0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
